mem_arb: RTL
============

# mem_arb

Shared memory-port arbiter and transaction sequencer for the core's load/store path. It accepts requests from three requesters and grants one at a time onto a single downstream memory port, with one transaction outstanding at a time:
- `axis`: DMA/debug.
- `ag`: data address-generate.
- `rd`: instruction fetch.

It tracks the transaction until its response returns and routes that response back tagged with the requester ID. A fetch anti-starvation counter and a response timeout bound every requester's wait.

## Interface
Parameters:
- STARVE_MAX, 4, number of consecutive non-fetch grants while fetch is pending before fetch is forced to win; range 1..15.
- TIMEOUT, 255, number of cycles after grant after which the transaction is aborted with an error; range 2..255.

Ports:
- clk  in  1  single clock; all logic is rising-edge.
- rst  in  1  synchronous, active-high reset.
- hs_axis4arb_val  in  1  axis request valid; held stable until accepted.
- hs_arb4axis_rdy  out  1  axis request accepted (one-cycle pulse).
- i_axis_adr / i_axis_wdat / i_axis_wen / i_axis_ren  in  32/32/4/1  axis request fields.
- hs_ag4arb_val, hs_arb4ag_rdy, i_ag_adr, i_ag_wdat, i_ag_wen, i_ag_ren  same as axis, for the ag requester.
- hs_rd4arb_val  in  1  fetch request valid.
- hs_arb4rd_rdy  out  1  fetch request accepted.
- i_pc  in  32  fetch address.
- o_m_val  out  1  downstream request valid.
- i_m_rdy  in  1  downstream accepts the request.
- o_m_adr / o_m_wdat / o_m_wen / o_m_ren  out  32/32/4/1  latched request fields.
- i_m_rsp_val  in  1  downstream response valid.
- i_m_rdat  in  32  downstream read data.
- o_rsp_val  out  1  response pulse to requesters.
- o_rsp_id  out  2  response owner: 0 = rd, 1 = ag, 2 = axis.
- o_rsp_err  out  1  the response is a timeout abort.
- o_rdat  out  32  response data.

## Operation
- States: IDLE, REQ, WAIT.
- **IDLE:**
  - Compute a winner from the valid requesters, using the priority axis > ag > rd.
  - If fetch is valid and starve_cnt == STARVE_MAX, rd wins instead.
  - Assert the winner's hs_arb4X_rdy combinationally.
  - At the clock edge:
    - Latch adr, wdat, wen and ren into the o_m_* registers. For rd: wdat = 0, wen = 0, ren = 1.
    - Latch the owner ID and clear tmo_cnt.
    - Go to REQ.
- **REQ:**
  - o_m_val = 1.
  - If i_m_rdy, go to WAIT.
- **WAIT:**
  - o_m_val = 0.
  - On i_m_rsp_val, register o_rdat = i_m_rdat, o_rsp_id = owner, o_rsp_err = 0 and o_rsp_val = 1 for one cycle. Go to IDLE.
- **starve_cnt** (4-bit), updated on each grant:
  - Cleared on an rd grant.
  - Incremented, saturating at STARVE_MAX, on an axis or ag grant while hs_rd4arb_val = 1.
  - Unchanged otherwise.
- **tmo_cnt** (8-bit):
  - Increments every cycle in REQ or WAIT.
  - When tmo_cnt == TIMEOUT - 1 and i_m_rsp_val = 0 in that cycle:
    - Register o_rsp_val = 1, o_rsp_err = 1, o_rdat = 0 and o_rsp_id = owner.
    - Drop o_m_val and go to IDLE.
  - If the response and the timeout coincide, the normal response wins (err = 0).
- i_m_rsp_val is ignored outside WAIT.
- The downstream port must not respond to a transaction after it has been aborted. This is a system constraint and is not checked.
- Only one requester's rdy is ever asserted in a cycle, and only in IDLE.
- The o_m_* fields hold their value from grant until the next grant.

## Timing
- Reset values:
  - State IDLE; starve_cnt = 0; tmo_cnt = 0.
  - o_m_val = 0; o_m_adr = 0; o_m_wdat = 0; o_m_wen = 0; o_m_ren = 0.
  - o_rsp_val = 0; o_rsp_err = 0; o_rsp_id = 0; o_rdat = 0.
  - All rdy outputs = 0.
- A reset asserted mid-transaction abandons the transaction. No response is produced, and the next grant follows deassertion.
- Grant sequence, with the grant in cycle T:
  - rdy pulses in cycle T.
  - o_m_val is high from T+1.
  - With i_m_rdy at T+1, the earliest i_m_rsp_val is at T+2, and o_rsp_val is high at T+3.
- The next grant can occur in the same cycle o_rsp_val is high (T+3), giving a minimum of 3 cycles per transaction.
- A timeout response appears TIMEOUT cycles after T+1, at T+1+TIMEOUT.
- Request fields are sampled only at the grant edge. Changes to a non-granted requester's fields have no effect.

## Test plan
- **Single fetch:**
  - Stimulus: hs_rd4arb_val with i_pc = 0x8000_0010; i_m_rdy tied 1; response one cycle later with rdat = 0xDEAD_BEEF.
  - Required: rdy at T; o_m_adr = 0x8000_0010 and o_m_ren = 1 at T+1; o_rsp_val = 1, id = 0, o_rdat = 0xDEAD_BEEF at T+3.
- **Priority:**
  - Stimulus: all three requesters valid in the same cycle.
  - Required: grants in order axis, ag, rd; exactly one rdy per grant; responses tagged 2, 1, 0.
- **Starvation (STARVE_MAX = 4):**
  - Stimulus: ag valid continuously and rd valid continuously.
  - Required: 4 ag grants, then an rd grant, then starve_cnt = 0 and ag resumes.
- **Backpressure:**
  - Stimulus: i_m_rdy held 0 for 10 cycles.
  - Required: o_m_val and o_m_* stable throughout; no rdy on any requester; normal response afterwards.
- **Timeout (TIMEOUT = 8):**
  - Stimulus: the response is never returned.
  - Required: o_rsp_val = 1 with err = 1 and o_rdat = 0 at T+9; a new grant possible at T+9.
  - Also: a response arriving in the timeout cycle itself yields err = 0.
- **Reset in WAIT:**
  - Stimulus: rst for 1 cycle while in WAIT.
  - Required: no o_rsp_val; all outputs return to their reset values; a pending requester is granted in the first cycle after rst deasserts.

Source files
------------

// File: rtl/mem_arb_if.sv
// rtl/mem_arb_if.sv - requester, downstream memory and response signals of the memory-port arbiter
interface mem_arb_if;
  logic        hs_axis4arb_val;
  logic        hs_arb4axis_rdy;
  logic [31:0] i_axis_adr;
  logic [31:0] i_axis_wdat;
  logic [3:0]  i_axis_wen;
  logic        i_axis_ren;

  logic        hs_ag4arb_val;
  logic        hs_arb4ag_rdy;
  logic [31:0] i_ag_adr;
  logic [31:0] i_ag_wdat;
  logic [3:0]  i_ag_wen;
  logic        i_ag_ren;

  logic        hs_rd4arb_val;
  logic        hs_arb4rd_rdy;
  logic [31:0] i_pc;

  logic        o_m_val;
  logic        i_m_rdy;
  logic [31:0] o_m_adr;
  logic [31:0] o_m_wdat;
  logic [3:0]  o_m_wen;
  logic        o_m_ren;
  logic        i_m_rsp_val;
  logic [31:0] i_m_rdat;

  logic        o_rsp_val;
  logic [1:0]  o_rsp_id;
  logic        o_rsp_err;
  logic [31:0] o_rdat;

  // Arbiter side.
  modport slave (
    input  hs_axis4arb_val, i_axis_adr, i_axis_wdat, i_axis_wen, i_axis_ren,
    input  hs_ag4arb_val, i_ag_adr, i_ag_wdat, i_ag_wen, i_ag_ren,
    input  hs_rd4arb_val, i_pc,
    input  i_m_rdy, i_m_rsp_val, i_m_rdat,
    output hs_arb4axis_rdy, hs_arb4ag_rdy, hs_arb4rd_rdy,
    output o_m_val, o_m_adr, o_m_wdat, o_m_wen, o_m_ren,
    output o_rsp_val, o_rsp_id, o_rsp_err, o_rdat
  );

  // Requesters and downstream memory side.
  modport master (
    output hs_axis4arb_val, i_axis_adr, i_axis_wdat, i_axis_wen, i_axis_ren,
    output hs_ag4arb_val, i_ag_adr, i_ag_wdat, i_ag_wen, i_ag_ren,
    output hs_rd4arb_val, i_pc,
    output i_m_rdy, i_m_rsp_val, i_m_rdat,
    input  hs_arb4axis_rdy, hs_arb4ag_rdy, hs_arb4rd_rdy,
    input  o_m_val, o_m_adr, o_m_wdat, o_m_wen, o_m_ren,
    input  o_rsp_val, o_rsp_id, o_rsp_err, o_rdat
  );
endinterface

// File: rtl/mem_arb.sv
// rtl/mem_arb.sv - three-way memory-port arbiter with one outstanding transaction,
// fetch anti-starvation and response timeout
module mem_arb #(
  parameter int STARVE_MAX = 4,
  parameter int TIMEOUT    = 255
) (
  input logic      clk,
  input logic      rst,
  mem_arb_if.slave bus
);
  typedef enum logic [1:0] {IDLE, REQ, WAIT} state_t;

  localparam logic [1:0] ID_RD   = 2'd0;
  localparam logic [1:0] ID_AG   = 2'd1;
  localparam logic [1:0] ID_AXIS = 2'd2;
  localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);
  localparam logic [7:0] TMO_LAST   = 8'(TIMEOUT - 1);

  state_t     state, state_nx;
  logic [3:0] starve_cnt;
  logic [7:0] tmo_cnt;
  logic [1:0] owner;
  logic       grant;
  logic [1:0] win_id;
  logic       rsp_hit;
  logic       tmo_hit;

  always_comb begin
    state_nx = state;
    grant    = 1'b0;
    win_id   = ID_RD;
    rsp_hit  = (state == WAIT) && bus.i_m_rsp_val;
    // A response landing in the timeout cycle beats the abort.
    tmo_hit  = (state != IDLE) && (tmo_cnt == TMO_LAST) && !rsp_hit;
    case (state)
      IDLE: begin
        if (!rst) begin
          if (bus.hs_rd4arb_val && starve_cnt == STARVE_LIM) begin
            grant  = 1'b1;
            win_id = ID_RD;
          end else if (bus.hs_axis4arb_val) begin
            grant  = 1'b1;
            win_id = ID_AXIS;
          end else if (bus.hs_ag4arb_val) begin
            grant  = 1'b1;
            win_id = ID_AG;
          end else if (bus.hs_rd4arb_val) begin
            grant  = 1'b1;
            win_id = ID_RD;
          end
          if (grant) state_nx = REQ;
        end
      end
      REQ: begin
        if (tmo_hit)          state_nx = IDLE;
        else if (bus.i_m_rdy) state_nx = WAIT;
      end
      WAIT: begin
        if (rsp_hit || tmo_hit) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  assign bus.hs_arb4axis_rdy = grant && (win_id == ID_AXIS);
  assign bus.hs_arb4ag_rdy   = grant && (win_id == ID_AG);
  assign bus.hs_arb4rd_rdy   = grant && (win_id == ID_RD);
  assign bus.o_m_val         = (state == REQ);

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      starve_cnt    <= '0;
      tmo_cnt       <= '0;
      owner         <= ID_RD;
      bus.o_m_adr   <= '0;
      bus.o_m_wdat  <= '0;
      bus.o_m_wen   <= '0;
      bus.o_m_ren   <= 1'b0;
      bus.o_rsp_val <= 1'b0;
      bus.o_rsp_err <= 1'b0;
      bus.o_rsp_id  <= '0;
      bus.o_rdat    <= '0;
    end else begin
      state         <= state_nx;
      bus.o_rsp_val <= 1'b0;
      if (grant) begin
        owner   <= win_id;
        tmo_cnt <= '0;
        case (win_id)
          ID_AXIS: begin
            bus.o_m_adr  <= bus.i_axis_adr;
            bus.o_m_wdat <= bus.i_axis_wdat;
            bus.o_m_wen  <= bus.i_axis_wen;
            bus.o_m_ren  <= bus.i_axis_ren;
          end
          ID_AG: begin
            bus.o_m_adr  <= bus.i_ag_adr;
            bus.o_m_wdat <= bus.i_ag_wdat;
            bus.o_m_wen  <= bus.i_ag_wen;
            bus.o_m_ren  <= bus.i_ag_ren;
          end
          default: begin
            bus.o_m_adr  <= bus.i_pc;
            bus.o_m_wdat <= '0;
            bus.o_m_wen  <= '0;
            bus.o_m_ren  <= 1'b1;
          end
        endcase
        // Count data-side grants that jumped a waiting fetch.
        if (win_id == ID_RD)
          starve_cnt <= '0;
        else if (bus.hs_rd4arb_val && starve_cnt < STARVE_LIM)
          starve_cnt <= starve_cnt + 4'd1;
      end else if (state != IDLE) begin
        tmo_cnt <= tmo_cnt + 8'd1;
      end
      if (rsp_hit) begin
        bus.o_rsp_val <= 1'b1;
        bus.o_rsp_err <= 1'b0;
        bus.o_rsp_id  <= owner;
        bus.o_rdat    <= bus.i_m_rdat;
      end else if (tmo_hit) begin
        bus.o_rsp_val <= 1'b1;
        bus.o_rsp_err <= 1'b1;
        bus.o_rsp_id  <= owner;
        bus.o_rdat    <= '0;
      end
    end
  end
endmodule
